// File: rtl/inst_rom_resp_pkg.sv
// Shared constants and types for the instruction-ROM responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package inst_rom_resp_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] INST_NOP = 32'h0000_0013;   // addi x0, x0, 0

    // Return-register contents, excluding the instruction word which lives
    // in the array's registered read port.
    typedef struct packed {
        logic [XLEN-1:0] pc;     // PC the returned word belongs to
        logic            vld;    // a real fetch is being returned
        logic            err;    // misaligned or out-of-range fetch
        logic            nop;    // substitute NOP for the array read data
    } ret_t;

endpackage

// File: rtl/inst_rom_resp_irom_array.sv
// DEPTH x 32 instruction array: one write port, one registered read port.
// Latency: 1 cycle, read data registered at the edge that samples rd_addr.
// Backpressure: rd_en=0 freezes rd_data; writes proceed regardless.
//
// Ports: clk; rd_en/rd_addr -> rd_data (read-first against a same-edge write);
//        wr_en/wr_addr/wr_data program-load port.
module irom_array
    import inst_rom_resp_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [XLEN-1:0]          rd_data,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [XLEN-1:0]          wr_data
);

    typedef logic [XLEN-1:0] image_t [DEPTH];

    // Power-on image: all NOP; contents are then supplied through the program-load port.
    function automatic image_t image_init();
        image_t img;
        for (int i = 0; i < DEPTH; i++) begin
            img[i] = INST_NOP;
        end
        return img;
    endfunction

    image_t mem = image_init();

    // Read and write share one block so a same-word collision returns the
    // pre-write contents.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/inst_rom_resp.sv
// Fetch-side instruction memory responder feeding the if/id register.
// Latency: 1 cycle, pc_i sampled at edge N is returned during cycle N+1.
// Backpressure: stall_i freezes every return output; flush_i turns the return into a bubble.
//
// Ports: clk, rst (sync, active-high); pc_i/flush_i/stall_i from fetch;
//        prog_we_i/prog_addr_i/prog_data_i program load;
//        inst_o/inst_pc_o/inst_valid_o/fetch_err_o return to if/id.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [31:0]              pc_i,
    input  logic                     flush_i,
    input  logic                     stall_i,
    input  logic                     prog_we_i,
    input  logic [$clog2(DEPTH)-1:0] prog_addr_i,
    input  logic [31:0]              prog_data_i,
    output logic [31:0]              inst_o,
    output logic [31:0]              inst_pc_o,
    output logic                     inst_valid_o,
    output logic                     fetch_err_o
);

    localparam int AW = $clog2(DEPTH);

    logic [29:0]   word_off;
    logic [AW-1:0] idx;
    logic          misalign;
    logic          out_of_range;
    logic          bad_fetch;
    logic [31:0]   rd_data;
    ret_t          ret_q;
    logic          first_q;

    // Word offset from the base; a pc below the base wraps to a huge offset
    // and so lands in the out-of-range case.
    assign word_off     = 30'((pc_i - BASE_ADDR) >> 2);
    assign idx          = word_off[AW-1:0];
    assign misalign     = (pc_i[1:0] != 2'b00);
    assign out_of_range = (word_off[29:AW] != '0);
    assign bad_fetch    = misalign | out_of_range;

    irom_array #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk     (clk),
        .rd_en   (~stall_i),
        .rd_addr (idx),
        .rd_data (rd_data),
        .wr_en   (prog_we_i),
        .wr_addr (prog_addr_i),
        .wr_data (prog_data_i)
    );

    // first_q swallows the fetch issued while reset was held (pc=0 from fetch),
    // so the first edge out of reset behaves like a flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_q   <= '{pc: '0, vld: 1'b0, err: 1'b0, nop: 1'b1};
            first_q <= 1'b1;
        end else if (!stall_i) begin
            first_q <= 1'b0;
            if (flush_i || first_q) begin
                ret_q <= '{pc: pc_i, vld: 1'b0, err: 1'b0, nop: 1'b1};
            end else begin
                ret_q <= '{pc: pc_i, vld: 1'b1, err: bad_fetch, nop: bad_fetch};
            end
        end
    end

    // The array read is masked rather than gated, so an out-of-range fetch
    // never exposes the aliased word.
    assign inst_o       = ret_q.nop ? INST_NOP : rd_data;
    assign inst_pc_o    = ret_q.pc;
    assign inst_valid_o = ret_q.vld;
    assign fetch_err_o  = ret_q.err;

endmodule

// File: tb/tb_inst_rom_resp.sv
// Scoreboard bench for inst_rom_resp: stimulus pushes expected returns, a monitor pops and compares.
// Latency: one expected entry per clock edge, checked 2 time units after that edge.
// Backpressure: stall/flush/reset are part of the randomized stimulus.
module tb_inst_rom_resp;

    localparam int          DEPTH = 64;
    localparam int          AW    = $clog2(DEPTH);
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk;
    logic          rst;
    logic [31:0]   pc_i;
    logic          flush_i;
    logic          stall_i;
    logic          prog_we_i;
    logic [AW-1:0] prog_addr_i;
    logic [31:0]   prog_data_i;
    logic [31:0]   inst_o;
    logic [31:0]   inst_pc_o;
    logic          inst_valid_o;
    logic          fetch_err_o;

    inst_rom_resp #(
        .DEPTH     (DEPTH),
        .INIT_FILE (""),
        .BASE_ADDR (BASE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .flush_i      (flush_i),
        .stall_i      (stall_i),
        .prog_we_i    (prog_we_i),
        .prog_addr_i  (prog_addr_i),
        .prog_data_i  (prog_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .fetch_err_o  (fetch_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        vld;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;

    // Reference model state: memory image plus the last returned fetch.
    logic [31:0] mm [DEPTH];
    exp_t        cur;
    bit          first;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expected entry per edge, compared shortly after the edge.
    always @(posedge clk) begin
        #2;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("inst",  inst_o,              e.inst);
            chk("pc",    inst_pc_o,           e.pc);
            chk("valid", 32'(inst_valid_o),   32'(e.vld));
            chk("err",   32'(fetch_err_o),    32'(e.err));
        end
    end

    // Drive one cycle, predict the return the coming edge produces, then wait.
    task automatic cyc(input bit r, input logic [31:0] pc, input bit fl, input bit st,
                       input bit we, input int wa, input logic [31:0] wd);
        logic [31:0] off;
        rst = r; pc_i = pc; flush_i = fl; stall_i = st;
        prog_we_i = we; prog_addr_i = AW'(wa); prog_data_i = wd;
        if (r) begin
            cur   = '{inst: NOP, pc: 32'h0, vld: 1'b0, err: 1'b0};
            first = 1'b1;
        end else if (!st) begin
            if (fl || first) begin
                cur = '{inst: NOP, pc: pc, vld: 1'b0, err: 1'b0};
            end else begin
                off = pc - BASE;
                if (pc % 4 != 0 || off >= DEPTH * 4)
                    cur = '{inst: NOP, pc: pc, vld: 1'b1, err: 1'b1};
                else
                    cur = '{inst: mm[off / 4], pc: pc, vld: 1'b1, err: 1'b0};
            end
            first = 1'b0;
        end
        if (we) mm[wa] = wd;      // after the read: same-edge read sees old data
        sb_q.push_back(cur);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Plain fetch helper.
    task automatic fetch(input logic [31:0] pc);
        cyc(1'b0, pc, 1'b0, 1'b0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        int w;
        logic [31:0] pc;
        for (int i = 0; i < DEPTH; i++) mm[i] = NOP;
        first = 1'b1;
        cur   = '{inst: NOP, pc: 32'h0, vld: 1'b0, err: 1'b0};

        // Reset, then program words 0..5 (also covers the swallowed first fetch).
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        cyc(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 0, 32'h0);
        for (int i = 0; i < 6; i++)
            cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, i, 32'(11 * (i + 1)));

        // Consecutive fetches.
        fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);

        // Flush bubble, then a normal fetch.
        cyc(1'b0, 32'h8, 1'b1, 1'b0, 1'b0, 0, 32'h0);
        fetch(32'd20);

        // Stall holds (including a flush under stall), release returns the new pc.
        fetch(32'h4);
        cyc(1'b0, 32'h8,  1'b0, 1'b1, 1'b0, 0, 32'h0);
        cyc(1'b0, 32'hC,  1'b1, 1'b1, 1'b0, 0, 32'h0);
        cyc(1'b0, 32'h10, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        fetch(32'h10);

        // Error cases: misaligned, one past the end, just below the base (wraps).
        fetch(32'h6);
        fetch(32'(DEPTH * 4));
        fetch(32'hFFFF_FFFC);
        fetch(32'(DEPTH * 4 - 4));

        // Read-first collision, then refetch sees the new word.
        cyc(1'b0, 32'h4, 1'b0, 1'b0, 1'b1, 1, 32'd55);
        fetch(32'h4);

        // Reset under stall mid-stream, then the first post-reset fetch is dropped.
        fetch(32'h8);
        cyc(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 0, 32'h0);
        fetch(32'h0);
        fetch(32'h4);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            w = int'($urandom_range(0, 99));
            if (w < 70)      pc = BASE + 32'($urandom_range(0, DEPTH - 1)) * 4;
            else if (w < 85) pc = BASE + 32'($urandom_range(0, DEPTH * 4 - 1));
            else             pc = $urandom;
            cyc($urandom_range(0, 99) < 3,
                pc,
                $urandom_range(0, 99) < 15,
                $urandom_range(0, 99) < 20,
                $urandom_range(0, 99) < 30,
                int'($urandom_range(0, DEPTH - 1)),
                $urandom);
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(posedge clk);
        #5;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
